frame_timer_ctrl: RTL and testbench

Frame timing controller that sequences one internal `flex_5bitcounter` instance to produce per-bit strobes for a serial frame of 1–16 bits. Each bit period is 2–31 clocks. The block drives the counter's `clear`, `count_enable` and `rollover_val`, and consumes its `rollover_flag`. It sits between the packet-level control FSM (which issues `start`/`abort`) and a shift register (which consumes `bit_strobe`).

---
 rtl/frame_timer_ctrl.sv | 141 ++++++++++++++
 tb/tb_frame_timer_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/frame_timer_ctrl.sv
// Frame timing controller: sequences a 5-bit flex counter to produce per-bit strobes.
// Optional mid-bit sample strobe is enabled by defining FRAME_TIMER_MIDBIT_EN.

module flex_5bitcounter (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       count_enable,
    input  logic [4:0] rollover_val,
    output logic [4:0] count_out,
    output logic       rollover_flag
);

    logic [4:0] next_count;

    always_comb begin
        next_count = count_out + 5'd1;
        if (count_out == rollover_val) begin
            next_count = 5'd1;
        end
    end

    // Flag is registered from the next count so it coincides with count_out == rollover_val.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else if (clear) begin
            count_out     <= '0;
            rollover_flag <= 1'b0;
        end else if (count_enable) begin
            count_out     <= next_count;
            rollover_flag <= (next_count == rollover_val);
        end
    end

endmodule

module frame_timer_ctrl (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       abort,
    input  logic [4:0] bit_period,
    input  logic [3:0] num_bits,
    output logic       busy,
    output logic       bit_strobe,
    output logic [3:0] bit_index,
    output logic       frame_done,
    output logic       sample_strobe
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [4:0] period_r;
    logic [4:0] period_n;
    logic [3:0] nbits_r;
    logic [3:0] nbits_n;
    logic [3:0] index_n;
    logic [4:0] count_out;
    logic       rollover_flag;
    logic       cnt_clear;
    logic       cnt_enable;

    assign cnt_clear  = (state == IDLE);
    assign cnt_enable = (state == COUNT);

    flex_5bitcounter u_counter (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear),
        .count_enable  (cnt_enable),
        .rollover_val  (period_r),
        .count_out     (count_out),
        .rollover_flag (rollover_flag)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            period_r  <= '0;
            nbits_r   <= '0;
            bit_index <= '0;
        end else begin
            state     <= next_state;
            period_r  <= period_n;
            nbits_r   <= nbits_n;
            bit_index <= index_n;
        end
    end

    always_comb begin
        next_state = state;
        period_n   = period_r;
        nbits_n    = nbits_r;
        index_n    = bit_index;
        busy       = 1'b0;
        bit_strobe = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    period_n   = (bit_period < 5'd2) ? 5'd2 : bit_period;
                    nbits_n    = num_bits;
                    index_n    = '0;
                    next_state = COUNT;
                end
            end
            COUNT: begin
                busy       = 1'b1;
                bit_strobe = rollover_flag;
                // Abort wins over a coincident strobe: no frame_done, index left as is.
                if (abort) begin
                    next_state = IDLE;
                end else if (rollover_flag) begin
                    if (bit_index == nbits_r - 4'd1) begin
                        frame_done = 1'b1;
                        next_state = IDLE;
                    end else begin
                        index_n = bit_index + 4'd1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

`ifdef FRAME_TIMER_MIDBIT_EN
    assign sample_strobe = (state == COUNT) && (count_out == {1'b0, period_r[4:1]});
`else
    logic unused_count;
    assign unused_count  = ^count_out;
    assign sample_strobe = 1'b0;
`endif

endmodule

// File: tb/tb_frame_timer_ctrl.sv
// Self-checking bench for frame_timer_ctrl: hand-derived vector table, corner sequences,
// and randomized frames checked against a cycle-arithmetic reference model.

module tb_frame_timer_ctrl;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic       abort;
    logic [4:0] bit_period;
    logic [3:0] num_bits;
    logic       busy;
    logic       bit_strobe;
    logic [3:0] bit_index;
    logic       frame_done;
    logic       sample_strobe;

    int n_tests = 0;
    int n_fail  = 0;
    int hold_idx = 0;

    frame_timer_ctrl dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .abort         (abort),
        .bit_period    (bit_period),
        .num_bits      (num_bits),
        .busy          (busy),
        .bit_strobe    (bit_strobe),
        .bit_index     (bit_index),
        .frame_done    (frame_done),
        .sample_strobe (sample_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] bp;
        logic [3:0] nb;
        int         abort_k;
        bit         junk;
        int         exp_first;
        int         exp_done;
    } vec_t;

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    // Reference: frame starting at cycle 0 with period p and length n.
    function automatic bit m_strobe(input int c, input int p);
        return (c >= 2) && ((c - 1) % p == 0);
    endfunction

    function automatic int m_index(input int c, input int p);
        return (c <= 1) ? 0 : (c - 2) / p;
    endfunction

    function automatic bit m_sample(input int c, input int p);
`ifdef FRAME_TIMER_MIDBIT_EN
        return (c >= 2) && (((c - 2) % p) + 1 == p / 2);
`else
        return (c < 0) && (p < 0);
`endif
    endfunction

    task automatic idle_cycles(input int n, input bit st, input bit ab);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start      = st;
            abort      = ab;
            bit_period = 5'($urandom_range(0, 31));
            num_bits   = 4'($urandom_range(0, 15));
            @(negedge clk);
            chk("idle_busy",   i, 32'(busy),          0);
            chk("idle_strobe", i, 32'(bit_strobe),    0);
            chk("idle_done",   i, 32'(frame_done),    0);
            chk("idle_sample", i, 32'(sample_strobe), 0);
            chk("idle_index",  i, 32'(bit_index),     32'(hold_idx));
        end
    endtask

    task automatic run_frame(input logic [4:0] bp, input logic [3:0] nb, input int abort_k,
                             input bit junk, output int first_c, output int done_c);
        int p, n, last, end_c;
        p     = (bp < 2) ? 2 : int'(bp);
        n     = (nb == 0) ? 16 : int'(nb);
        last  = n * p + 1;
        end_c = (abort_k > 0) ? abort_k : last;
        first_c = -1;
        done_c  = -1;
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b0; bit_period = bp; num_bits = nb;
        @(negedge clk);
        chk("c0_busy",   0, 32'(busy),       0);
        chk("c0_strobe", 0, 32'(bit_strobe), 0);
        chk("c0_index",  0, 32'(bit_index),  32'(hold_idx));
        for (int c = 1; c <= end_c; c++) begin
            @(posedge clk); #1;
            start = junk && (c == 3);
            abort = (c == abort_k);
            if (junk) begin
                bit_period = 5'($urandom_range(0, 31));
                num_bits   = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            if (bit_strobe && first_c < 0) first_c = c;
            if (frame_done) done_c = c;
            chk("busy",   c, 32'(busy),          1);
            chk("strobe", c, 32'(bit_strobe),    32'(m_strobe(c, p)));
            chk("index",  c, 32'(bit_index),     32'(m_index(c, p)));
            chk("done",   c, 32'(frame_done),    32'(m_strobe(c, p) && c == last && c != abort_k));
            chk("sample", c, 32'(sample_strobe), 32'(m_sample(c, p)));
        end
        hold_idx = m_index(end_c, p);
    endtask

    vec_t vecs[10];
    int   fc, dc;

    initial begin
        vecs[0] = '{5'd4,  4'd3,  0, 1'b0, 5,  13};
        vecs[1] = '{5'd1,  4'd0,  0, 1'b0, 3,  33};
        vecs[2] = '{5'd31, 4'd1,  0, 1'b0, 32, 32};
        vecs[3] = '{5'd5,  4'd4,  8, 1'b0, 6,  -1};
        vecs[4] = '{5'd5,  4'd4,  0, 1'b0, 6,  21};
        vecs[5] = '{5'd6,  4'd2,  0, 1'b0, 7,  13};
        vecs[6] = '{5'd7,  4'd5,  0, 1'b1, 8,  36};
        vecs[7] = '{5'd0,  4'd1,  0, 1'b0, 3,  3};
        vecs[8] = '{5'd2,  4'd15, 0, 1'b1, 3,  31};
        vecs[9] = '{5'd3,  4'd0,  0, 1'b0, 4,  49};

        n_rst = 1'b0; start = 1'b0; abort = 1'b0; bit_period = '0; num_bits = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",  0, 32'(busy),       0);
        chk("rst_index", 0, 32'(bit_index),  0);
        chk("rst_done",  0, 32'(frame_done), 0);
        n_rst = 1'b1;

        // Reset mid-frame (p=4, N=3, reset in cycle 6).
        @(posedge clk); #1;
        start = 1'b1; bit_period = 5'd4; num_bits = 4'd3;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        chk("midrst_busy",   6, 32'(busy),          0);
        chk("midrst_strobe", 6, 32'(bit_strobe),    0);
        chk("midrst_index",  6, 32'(bit_index),     0);
        chk("midrst_done",   6, 32'(frame_done),    0);
        chk("midrst_sample", 6, 32'(sample_strobe), 0);
        @(negedge clk);
        n_rst = 1'b1;
        hold_idx = 0;

        for (int i = 0; i < 10; i++) begin
            run_frame(vecs[i].bp, vecs[i].nb, vecs[i].abort_k, vecs[i].junk, fc, dc);
            chk("tbl_first", i, 32'(fc), 32'(vecs[i].exp_first));
            chk("tbl_done",  i, 32'(dc), 32'(vecs[i].exp_done));
        end

        idle_cycles(1, 1'b0, 1'b0);
        idle_cycles(1, 1'b1, 1'b1);
        idle_cycles(2, 1'b0, 1'b1);
        idle_cycles(2, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            logic [4:0] bp;
            logic [3:0] nb;
            int p, n, k;
            bp = 5'($urandom_range(0, 31));
            nb = 4'($urandom_range(0, 15));
            p  = (bp < 2) ? 2 : int'(bp);
            n  = (nb == 0) ? 16 : int'(nb);
            k  = 0;
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(1, n * p + 1);
                if (k >= 2 && ((k - 1) % p == 0)) k = k - 1;
            end
            run_frame(bp, nb, k, ($urandom_range(0, 2) == 0), fc, dc);
            chk("rnd_done", i, 32'(dc), (k > 0) ? 32'hFFFF_FFFF : 32'(n * p + 1));
            idle_cycles($urandom_range(0, 2), 1'b0, 1'b0);
        end

        idle_cycles(2, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
